mem_access_ctrl: RTL and testbench

- Sequencer and arbiter in front of the key-transformed 1024x32 memory.
- Shares the memory's single address/data port between two requesters using round-robin arbitration.
- Serialises key-transform commands so that a transform never overlaps a memory access.
- Returns the key bus to the neutral value 16'h0000 after every transform, so a repeated identical code still produces a key change.

---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter sharing one memory port between two round-robin requesters and key-transform commands.
// Reads take 2 edges accept-to-response; key sequences hold the code KEY_HOLD cycles and then return the key to 0.
module mem_access_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int KEY_W    = 16,
  parameter int KEY_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              key_cmd_valid,
  input  logic [KEY_W-1:0]  key_cmd_code,
  output logic              key_cmd_ready,
  output logic              key_busy,
  output logic              key_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic [KEY_W-1:0]  mem_key_access,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [KEY_W-1:0]  mem_key_echo
);

  localparam int CNT_W = (KEY_HOLD > 1) ? $clog2(KEY_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, KEY_APPLY, KEY_CLEAR} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                gnt_q, gnt_d;
  logic                rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
  logic [DATA_W-1:0]   rsp0_dat_q, rsp0_dat_d, rsp1_dat_q, rsp1_dat_d;

  logic idle, pick1, key_legal, sel_write;

  // rr_q=0 favours req0; a lone valid requester always wins
  assign idle          = (state_q == IDLE);
  assign pick1         = req1_valid & (~req0_valid | rr_q);
  assign key_cmd_ready = idle & key_cmd_valid;
  assign req0_ready    = idle & ~key_cmd_valid & req0_valid & ~pick1;
  assign req1_ready    = idle & ~key_cmd_valid & pick1;
  assign sel_write     = pick1 ? req1_write : req0_write;
  assign key_legal     = (key_cmd_code == KEY_W'(16'h0032)) || (key_cmd_code == KEY_W'(16'h0087)) ||
                         (key_cmd_code == KEY_W'(16'h1024)) || (key_cmd_code == KEY_W'(16'h0324));

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    key_d      = key_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    rsp0_vld_d = 1'b0;
    rsp1_vld_d = 1'b0;
    rsp0_dat_d = rsp0_dat_q;
    rsp1_dat_d = rsp1_dat_q;
    case (state_q)
      IDLE: begin
        if (key_cmd_valid) begin
          if (key_legal) begin
            key_d   = key_cmd_code;
            cnt_d   = CNT_W'(KEY_HOLD - 1);
            busy_d  = 1'b1;
            state_d = KEY_APPLY;
          end else begin
            err_d = 1'b1;
          end
        end else if (req0_ready || req1_ready) begin
          gnt_d   = pick1;
          addr_d  = pick1 ? req1_addr : req0_addr;
          wdata_d = pick1 ? req1_wdata : req0_wdata;
          wr_d    = sel_write;
          rd_d    = ~sel_write;
          rr_d    = ~pick1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = rd_q ? CAPTURE : IDLE;
      CAPTURE: begin
        if (gnt_q) begin
          rsp1_vld_d = 1'b1;
          rsp1_dat_d = mem_read_data;
        end else begin
          rsp0_vld_d = 1'b1;
          rsp0_dat_d = mem_read_data;
        end
        state_d = IDLE;
      end
      KEY_APPLY: begin
        if (cnt_q == '0) begin
          err_d   = (mem_key_echo != key_q);
          key_d   = '0;
          state_d = KEY_CLEAR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      KEY_CLEAR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      gnt_q      <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      key_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      rsp0_dat_q <= '0;
      rsp1_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
      rsp0_dat_q <= rsp0_dat_d;
      rsp1_dat_q <= rsp1_dat_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write      = wr_q;
  assign mem_key_access = key_q;
  assign key_busy       = busy_q;
  assign key_err        = err_q;
  assign rsp0_valid     = rsp0_vld_q;
  assign rsp1_valid     = rsp1_vld_q;
  assign rsp0_rdata     = rsp0_dat_q;
  assign rsp1_rdata     = rsp1_dat_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural memory and a response scoreboard.
module tb_mem_access_ctrl;
  localparam int AW = 10, DW = 32, KW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          key_cmd_valid, key_cmd_ready, key_busy, key_err;
  logic [KW-1:0] key_cmd_code;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write;
  logic [KW-1:0] mem_key_access, mem_key_echo, echo_flip;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW), .KEY_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .key_cmd_valid(key_cmd_valid), .key_cmd_code(key_cmd_code), .key_cmd_ready(key_cmd_ready),
    .key_busy(key_busy), .key_err(key_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_key_access(mem_key_access), .mem_read_data(mem_read_data), .mem_key_echo(mem_key_echo)
  );

  // Memory: samples the port on the rising edge, read data valid the following cycle
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] mem_rd;
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    mem_rd <= mem[mem_address];
  end
  assign mem_read_data = mem_rd;
  assign mem_key_echo  = mem_key_access ^ echo_flip;

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct packed { logic port; logic [DW-1:0] data; } exp_t;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] shadow [1024];
  int            gid[$], gcyc[$];
  logic [KW-1:0] klog[$];
  logic [KW-1:0] kprev = '0;
  int cyc = 0, wr_cycles = 0, kerr_cnt = 0, kacc_cnt = 0, rsp_cnt = 0;
  int base, rsp_base;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        gid.push_back(0); gcyc.push_back(cyc);
        if (req0_write) shadow[req0_addr] = req0_wdata;
        else sb.push_back({1'b0, shadow[req0_addr]});
      end
      if (req1_valid && req1_ready) begin
        gid.push_back(1); gcyc.push_back(cyc);
        if (req1_write) shadow[req1_addr] = req1_wdata;
        else sb.push_back({1'b1, shadow[req1_addr]});
      end
    end
    if (rsp0_valid || rsp1_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_port", {30'b0, rsp1_valid, rsp0_valid}, mon_e.port ? 32'd2 : 32'd1);
        chk("rsp_data", mon_e.port ? rsp1_rdata : rsp0_rdata, mon_e.data);
      end
    end
    if (mem_write) wr_cycles++;
    if (key_err) kerr_cnt++;
    if (key_cmd_valid && key_cmd_ready) kacc_cnt++;
    if (mem_key_access !== kprev) begin
      klog.push_back(mem_key_access);
      kprev = mem_key_access;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle budget exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; echo_flip = '0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    key_cmd_valid = 0; key_cmd_code = '0;
    tick(); tick();
    chk("rst_mem_write", mem_write, 0);
    chk("rst_key_access", mem_key_access, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_key_busy", key_busy, 0);
    rst_n = 1'b1;
    tick();

    // Write then read back through requester 0
    wr_cycles = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 10'h005; req0_wdata = 32'hDEADBEEF;
    #1 chk("t1_wr_ready", req0_ready, 1);
    tick(); req0_valid = 0;
    chk("t1_mem_write_issue", mem_write, 1);
    chk("t1_mem_addr", mem_address, 10'h005);
    chk("t1_mem_wdata", mem_write_data, 32'hDEADBEEF);
    tick();
    chk("t1_mem_write_drop", mem_write, 0);
    req0_valid = 1; req0_write = 0;
    tick(); req0_valid = 0;
    chk("t1_rsp_after_e0", rsp0_valid, 0);
    tick(); chk("t1_rsp_after_e1", rsp0_valid, 0);
    tick();
    chk("t1_rsp_after_e2", rsp0_valid, 1);
    chk("t1_rdata", rsp0_rdata, 32'hDEADBEEF);
    chk("t1_rsp1_quiet", rsp1_valid, 0);
    tick();
    chk("t1_rsp_pulse", rsp0_valid, 0);
    chk("t1_rdata_hold", rsp0_rdata, 32'hDEADBEEF);
    chk("t1_write_pulses", wr_cycles, 1);

    // Preload addresses 2 and 1, ending with the pointer back on req0
    req0_valid = 1; req0_write = 1; req0_addr = 10'h002; req0_wdata = 32'h2222_2222;
    tick(); req0_valid = 0; tick();
    req1_valid = 1; req1_write = 1; req1_addr = 10'h001; req1_wdata = 32'h1111_1111;
    tick(); req1_valid = 0; tick();

    // Both requesters reading continuously
    gid.delete(); gcyc.delete();
    req0_valid = 1; req0_write = 0; req0_addr = 10'h001;
    req1_valid = 1; req1_write = 0; req1_addr = 10'h002;
    repeat (11) tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    chk("t2_grant_count", gid.size(), 4);
    if (gid.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_grant_order", gid[i], i % 2);
      for (int i = 1; i < 4; i++) chk("t2_grant_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    chk("t2_sb_drained", sb.size(), 0);

    // Legal key code with matching echo
    base = kerr_cnt;
    key_cmd_valid = 1; key_cmd_code = 16'h0324;
    #1 chk("t3_key_ready", key_cmd_ready, 1);
    tick(); key_cmd_valid = 0;
    chk("t3_key_hold1", mem_key_access, 16'h0324); chk("t3_busy1", key_busy, 1);
    tick();
    chk("t3_key_hold2", mem_key_access, 16'h0324); chk("t3_busy2", key_busy, 1);
    tick();
    chk("t3_key_clear", mem_key_access, 16'h0000); chk("t3_busy3", key_busy, 1);
    tick();
    chk("t3_key_idle", mem_key_access, 16'h0000); chk("t3_busy_done", key_busy, 0);
    chk("t3_no_err", kerr_cnt - base, 0);

    // Same code twice back-to-back
    klog.delete();
    base = kacc_cnt;
    key_cmd_valid = 1; key_cmd_code = 16'h0324;
    for (int i = 0; i < 20 && (kacc_cnt - base) < 2; i++) tick();
    key_cmd_valid = 0;
    repeat (5) tick();
    chk("t4_accepts", kacc_cnt - base, 2);
    chk("t4_transitions", klog.size(), 4);
    if (klog.size() == 4) begin
      chk("t4_seq0", klog[0], 16'h0324);
      chk("t4_seq1", klog[1], 16'h0000);
      chk("t4_seq2", klog[2], 16'h0324);
      chk("t4_seq3", klog[3], 16'h0000);
    end

    // Echo mismatch still completes the sequence
    base = kerr_cnt;
    echo_flip = 16'h0001;
    key_cmd_valid = 1; key_cmd_code = 16'h0087;
    tick(); key_cmd_valid = 0;
    repeat (4) tick();
    chk("t4e_echo_err", kerr_cnt - base, 1);
    chk("t4e_busy_done", key_busy, 0);
    chk("t4e_key_clear", mem_key_access, 16'h0000);
    echo_flip = '0;

    // Illegal code
    base = kerr_cnt;
    key_cmd_valid = 1; key_cmd_code = 16'h1234;
    #1 chk("t5_key_ready", key_cmd_ready, 1);
    tick(); key_cmd_valid = 0;
    chk("t5_err_pulse", key_err, 1);
    chk("t5_key_unchanged", mem_key_access, 16'h0000);
    chk("t5_busy_low", key_busy, 0);
    tick();
    chk("t5_err_single", key_err, 0);
    chk("t5_err_count", kerr_cnt - base, 1);

    // Key command beats a simultaneous req1 read
    key_cmd_valid = 1; key_cmd_code = 16'h0032;
    req1_valid = 1; req1_write = 0; req1_addr = 10'h001;
    #1 chk("t6_req1_blocked", req1_ready, 0);
    tick(); key_cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_req1_wait", req1_ready, 0);
      tick();
    end
    chk("t6_req1_grant", req1_ready, 1);
    tick(); req1_valid = 0;
    repeat (3) tick();
    chk("t6_sb_drained", sb.size(), 0);

    // Reset in CAPTURE of a req0 read
    rsp_base = rsp_cnt;
    req0_valid = 1; req0_write = 0; req0_addr = 10'h002;
    tick(); req0_valid = 0;
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_mem_write", mem_write, 0);
    chk("t6_rst_addr", mem_address, 0);
    chk("t6_rst_wdata", mem_write_data, 0);
    chk("t6_rst_rsp0_rdata", rsp0_rdata, 0);
    chk("t6_rst_rsp1_rdata", rsp1_rdata, 0);
    chk("t6_rst_busy", key_busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_rsp", rsp_cnt - rsp_base, 0);
    req0_valid = 1; req0_addr = 10'h002;
    req1_valid = 1; req1_addr = 10'h001;
    #1;
    chk("t6_post_rst_req0", req0_ready, 1);
    chk("t6_post_rst_req1", req1_ready, 0);
    tick(); req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    chk("t6_final_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
